// File: rtl/pmp_csr_file.sv
// pmp_csr_file: machine-mode CSR storage for a 16-entry PMP unit.
// Holds pmpcfg0-3 and pmpaddr0-15, applies lock/WARL rules on writes and
// drives flop-output cfg/addr buses to the PMP permission checker.
// Optional feature macro: PMP_NA4_EN (when defined, A=NA4 is stored as written;
// otherwise a write carrying A=NA4 keeps the previously stored A field).
module pmp_csr_file #(
  parameter int unsigned PMP_ENTRIES  = 16,
  parameter logic [11:0] PMPCFG_BASE  = 12'h3A0,
  parameter logic [11:0] PMPADDR_BASE = 12'h3B0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_csr_addr,
  input  logic        i_csr_we,
  input  logic        i_csr_re,
  input  logic [31:0] i_csr_wdata,
  input  logic [1:0]  i_priv_mode,
  output logic [31:0] o_csr_rdata,
  output logic        o_csr_rvalid,
  output logic        o_csr_illegal,
  output logic        o_pmp_update,
  output logic [31:0] o_pmpcfg0_data,
  output logic [31:0] o_pmpcfg1_data,
  output logic [31:0] o_pmpcfg2_data,
  output logic [31:0] o_pmpcfg3_data,
  output logic [31:0] o_pmpaddr0_data,
  output logic [31:0] o_pmpaddr1_data,
  output logic [31:0] o_pmpaddr2_data,
  output logic [31:0] o_pmpaddr3_data,
  output logic [31:0] o_pmpaddr4_data,
  output logic [31:0] o_pmpaddr5_data,
  output logic [31:0] o_pmpaddr6_data,
  output logic [31:0] o_pmpaddr7_data,
  output logic [31:0] o_pmpaddr8_data,
  output logic [31:0] o_pmpaddr9_data,
  output logic [31:0] o_pmpaddr10_data,
  output logic [31:0] o_pmpaddr11_data,
  output logic [31:0] o_pmpaddr12_data,
  output logic [31:0] o_pmpaddr13_data,
  output logic [31:0] o_pmpaddr14_data,
  output logic [31:0] o_pmpaddr15_data
);

`ifdef PMP_NA4_EN
  localparam bit NA4_EN = 1'b1;
`else
  localparam bit NA4_EN = 1'b0;
`endif

  // One bit per entry; unimplemented entries never take writes and so stay 0.
  localparam logic [15:0] IMPL_MASK = 16'((33'h1 << PMP_ENTRIES) - 33'h1);

  logic [15:0][7:0]  r_cfg;
  logic [15:0][31:0] r_addr;
  logic [15:0][7:0]  w_cfg_d;
  logic [15:0][31:0] w_addr_d;
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_illegal;
  logic              r_update;

  logic [11:0] w_cfg_off;
  logic [11:0] w_addr_off;
  logic        w_cfg_hit;
  logic        w_addr_hit;
  logic        w_hit;
  logic        w_priv_m;
  logic        w_wr_ok;
  logic        w_rd_ok;
  logic [31:0] w_rd_val;
  logic [3:0]  w_aidx;
  logic [3:0]  w_anext;
  logic        w_addr_locked;

  assign w_cfg_off  = i_csr_addr - PMPCFG_BASE;
  assign w_addr_off = i_csr_addr - PMPADDR_BASE;
  assign w_cfg_hit  = (w_cfg_off < 12'd4);
  assign w_addr_hit = (w_addr_off < 12'd16);
  assign w_hit      = w_cfg_hit | w_addr_hit;
  assign w_priv_m   = (i_priv_mode == 2'b11);
  assign w_wr_ok    = w_hit & i_csr_we & w_priv_m;
  assign w_rd_ok    = w_hit & i_csr_re & w_priv_m;
  assign w_aidx     = w_addr_off[3:0];
  assign w_anext    = w_aidx + 4'd1;

  // A locked TOR entry also protects the address register below it (its base).
  assign w_addr_locked = r_cfg[w_aidx][7] |
                         ((w_aidx != 4'd15) & r_cfg[w_anext][7] &
                          (r_cfg[w_anext][4:3] == 2'b01));

  // WARL legalisation of one cfg byte; old_b supplies A when NA4 is unsupported.
  function automatic logic [7:0] cfg_legalise(input logic [7:0] old_b,
                                              input logic [7:0] new_b);
    logic [7:0] b;
    b = new_b & 8'h9F;
    if (!b[0] && b[1]) b[1] = 1'b0;
    if (!NA4_EN && (new_b[4:3] == 2'b10)) b[4:3] = old_b[4:3];
    return b;
  endfunction

  // Read mux from pre-write storage, so a same-cycle write never leaks in.
  always_comb begin
    w_rd_val = 32'h0;
    if (w_cfg_hit) begin
      w_rd_val = {r_cfg[{w_cfg_off[1:0], 2'd3}], r_cfg[{w_cfg_off[1:0], 2'd2}],
                  r_cfg[{w_cfg_off[1:0], 2'd1}], r_cfg[{w_cfg_off[1:0], 2'd0}]};
    end else if (w_addr_hit) begin
      w_rd_val = r_addr[w_aidx];
    end
  end

  // Next-state for cfg/addr storage; lock checks use stored (pre-write) cfg.
  always_comb begin
    w_cfg_d  = r_cfg;
    w_addr_d = r_addr;
    if (w_wr_ok && w_cfg_hit) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (IMPL_MASK[{w_cfg_off[1:0], 2'(k)}] && !r_cfg[{w_cfg_off[1:0], 2'(k)}][7]) begin
          w_cfg_d[{w_cfg_off[1:0], 2'(k)}] =
            cfg_legalise(r_cfg[{w_cfg_off[1:0], 2'(k)}], i_csr_wdata[8*k +: 8]);
        end
      end
    end
    if (w_wr_ok && w_addr_hit && IMPL_MASK[w_aidx] && !w_addr_locked) begin
      w_addr_d[w_aidx] = i_csr_wdata;
    end
  end

  // Storage update and registered read/status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cfg     <= '0;
      r_addr    <= '0;
      r_rdata   <= 32'h0;
      r_rvalid  <= 1'b0;
      r_illegal <= 1'b0;
      r_update  <= 1'b0;
    end else begin
      r_cfg     <= w_cfg_d;
      r_addr    <= w_addr_d;
      r_rvalid  <= w_rd_ok;
      r_illegal <= w_hit & (i_csr_we | i_csr_re) & ~w_priv_m;
      r_update  <= (w_cfg_d != r_cfg) | (w_addr_d != r_addr);
      if (w_rd_ok) r_rdata <= w_rd_val;
    end
  end

  assign o_csr_rdata   = r_rdata;
  assign o_csr_rvalid  = r_rvalid;
  assign o_csr_illegal = r_illegal;
  assign o_pmp_update  = r_update;

  assign o_pmpcfg0_data = {r_cfg[3],  r_cfg[2],  r_cfg[1],  r_cfg[0]};
  assign o_pmpcfg1_data = {r_cfg[7],  r_cfg[6],  r_cfg[5],  r_cfg[4]};
  assign o_pmpcfg2_data = {r_cfg[11], r_cfg[10], r_cfg[9],  r_cfg[8]};
  assign o_pmpcfg3_data = {r_cfg[15], r_cfg[14], r_cfg[13], r_cfg[12]};

  assign o_pmpaddr0_data  = r_addr[0];
  assign o_pmpaddr1_data  = r_addr[1];
  assign o_pmpaddr2_data  = r_addr[2];
  assign o_pmpaddr3_data  = r_addr[3];
  assign o_pmpaddr4_data  = r_addr[4];
  assign o_pmpaddr5_data  = r_addr[5];
  assign o_pmpaddr6_data  = r_addr[6];
  assign o_pmpaddr7_data  = r_addr[7];
  assign o_pmpaddr8_data  = r_addr[8];
  assign o_pmpaddr9_data  = r_addr[9];
  assign o_pmpaddr10_data = r_addr[10];
  assign o_pmpaddr11_data = r_addr[11];
  assign o_pmpaddr12_data = r_addr[12];
  assign o_pmpaddr13_data = r_addr[13];
  assign o_pmpaddr14_data = r_addr[14];
  assign o_pmpaddr15_data = r_addr[15];

endmodule

// File: tb/tb_pmp_csr_file.sv
// Directed self-checking bench for pmp_csr_file.
module tb_pmp_csr_file;

  logic        clk;
  logic        rst_n;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic        csr_re;
  logic [31:0] csr_wdata;
  logic [1:0]  priv_mode;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic        csr_illegal;
  logic        pmp_update;
  logic [31:0] cfg_o [4];
  logic [31:0] addr_o [16];

  int n_cmp = 0;
  int n_err = 0;

  pmp_csr_file dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_csr_addr       (csr_addr),
    .i_csr_we         (csr_we),
    .i_csr_re         (csr_re),
    .i_csr_wdata      (csr_wdata),
    .i_priv_mode      (priv_mode),
    .o_csr_rdata      (csr_rdata),
    .o_csr_rvalid     (csr_rvalid),
    .o_csr_illegal    (csr_illegal),
    .o_pmp_update     (pmp_update),
    .o_pmpcfg0_data   (cfg_o[0]),
    .o_pmpcfg1_data   (cfg_o[1]),
    .o_pmpcfg2_data   (cfg_o[2]),
    .o_pmpcfg3_data   (cfg_o[3]),
    .o_pmpaddr0_data  (addr_o[0]),
    .o_pmpaddr1_data  (addr_o[1]),
    .o_pmpaddr2_data  (addr_o[2]),
    .o_pmpaddr3_data  (addr_o[3]),
    .o_pmpaddr4_data  (addr_o[4]),
    .o_pmpaddr5_data  (addr_o[5]),
    .o_pmpaddr6_data  (addr_o[6]),
    .o_pmpaddr7_data  (addr_o[7]),
    .o_pmpaddr8_data  (addr_o[8]),
    .o_pmpaddr9_data  (addr_o[9]),
    .o_pmpaddr10_data (addr_o[10]),
    .o_pmpaddr11_data (addr_o[11]),
    .o_pmpaddr12_data (addr_o[12]),
    .o_pmpaddr13_data (addr_o[13]),
    .o_pmpaddr14_data (addr_o[14]),
    .o_pmpaddr15_data (addr_o[15])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One access: strobes held for one rising edge; returns at the following
  // falling edge, i.e. inside the cycle where the response is visible.
  task automatic csr_op(input logic we, input logic re, input logic [11:0] a,
                        input logic [31:0] d, input logic [1:0] pm);
    @(negedge clk);
    csr_we = we; csr_re = re; csr_addr = a; csr_wdata = d; priv_mode = pm;
    @(negedge clk);
    csr_we = 1'b0; csr_re = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_cfg4;

  initial begin
    rst_n = 1'b0; csr_we = 1'b0; csr_re = 1'b0; csr_addr = 12'h0;
    csr_wdata = 32'h0; priv_mode = 2'b11;
    repeat (2) @(negedge clk);
    check("rst_rdata", csr_rdata, 32'h0);
    check("rst_rvalid", {31'h0, csr_rvalid}, 32'h0);
    check("rst_illegal", {31'h0, csr_illegal}, 32'h0);
    check("rst_update", {31'h0, pmp_update}, 32'h0);
    check("rst_cfg0", cfg_o[0], 32'h0);
    check("rst_addr2", addr_o[2], 32'h0);
    rst_n = 1'b1;

    // Read pmpcfg0 after reset
    csr_op(1'b0, 1'b1, 12'h3A0, 32'h0, 2'b11);
    check("rd_cfg0_rvalid", {31'h0, csr_rvalid}, 32'h1);
    check("rd_cfg0_rdata", csr_rdata, 32'h0);
    check("rd_cfg0_update", {31'h0, pmp_update}, 32'h0);
    @(negedge clk);
    check("rvalid_pulse", {31'h0, csr_rvalid}, 32'h0);

    // pmpaddr2 write / readback / idempotent rewrite
    csr_op(1'b1, 1'b0, 12'h3B2, 32'h2000_0400, 2'b11);
    check("wr_addr2_bus", addr_o[2], 32'h2000_0400);
    check("wr_addr2_update", {31'h0, pmp_update}, 32'h1);
    csr_op(1'b0, 1'b1, 12'h3B2, 32'h0, 2'b11);
    check("rd_addr2_rdata", csr_rdata, 32'h2000_0400);
    check("rd_addr2_rvalid", {31'h0, csr_rvalid}, 32'h1);
    check("update_once", {31'h0, pmp_update}, 32'h0);
    csr_op(1'b1, 1'b0, 12'h3B2, 32'h2000_0400, 2'b11);
    check("same_wr_no_update", {31'h0, pmp_update}, 32'h0);

    // cfg WARL: R=0,W=1 clears W; byte1 0x8F stored unchanged
    csr_op(1'b1, 1'b0, 12'h3A0, 32'h0000_8F02, 2'b11);
    check("cfg_warl_bus", cfg_o[0], 32'h0000_8F00);
    check("cfg_warl_update", {31'h0, pmp_update}, 32'h1);
    csr_op(1'b0, 1'b1, 12'h3A0, 32'h0, 2'b11);
    check("cfg_warl_rd", csr_rdata, 32'h0000_8F00);

    // Bits [6:5] forced to 0: 0x63 -> 0x03
    csr_op(1'b1, 1'b0, 12'h3A2, 32'h0000_0063, 2'b11);
    check("cfg_bits65", cfg_o[2], 32'h0000_0003);

    // Lock / TOR protection
    do_reset();
    check("rst2_cfg0", cfg_o[0], 32'h0);
    csr_op(1'b1, 1'b0, 12'h3B0, 32'h0000_AAAA, 2'b11);
    csr_op(1'b1, 1'b0, 12'h3B1, 32'h0000_BBBB, 2'b11);
    csr_op(1'b1, 1'b0, 12'h3A0, 32'h0000_8900, 2'b11);
    check("lock_cfg1_set", cfg_o[0], 32'h0000_8900);
    csr_op(1'b1, 1'b0, 12'h3B0, 32'h0000_1234, 2'b11);
    check("tor_base_ignored", addr_o[0], 32'h0000_AAAA);
    check("tor_base_no_update", {31'h0, pmp_update}, 32'h0);
    csr_op(1'b1, 1'b0, 12'h3B1, 32'h0000_5678, 2'b11);
    check("locked_addr_ignored", addr_o[1], 32'h0000_BBBB);
    check("locked_addr_no_update", {31'h0, pmp_update}, 32'h0);
    csr_op(1'b1, 1'b0, 12'h3A0, 32'h0000_0000, 2'b11);
    check("lock_sticky", cfg_o[0], 32'h0000_8900);
    check("lock_sticky_no_update", {31'h0, pmp_update}, 32'h0);
    csr_op(1'b1, 1'b0, 12'h3B2, 32'h0000_0042, 2'b11);
    check("unlocked_addr2_wr", addr_o[2], 32'h0000_0042);

    // Privilege violation
    csr_op(1'b1, 1'b0, 12'h3B5, 32'hFFFF_FFFF, 2'b00);
    check("illegal_pulse", {31'h0, csr_illegal}, 32'h1);
    check("illegal_no_rvalid", {31'h0, csr_rvalid}, 32'h0);
    check("illegal_addr5", addr_o[5], 32'h0);
    check("illegal_no_update", {31'h0, pmp_update}, 32'h0);
    @(negedge clk);
    check("illegal_one_cycle", {31'h0, csr_illegal}, 32'h0);

    // Non-hit accesses are ignored entirely
    csr_op(1'b0, 1'b1, 12'h3C0, 32'h0, 2'b00);
    check("nonhit_illegal", {31'h0, csr_illegal}, 32'h0);
    check("nonhit_rvalid", {31'h0, csr_rvalid}, 32'h0);
    csr_op(1'b0, 1'b1, 12'h39F, 32'h0, 2'b11);
    check("nonhit_rvalid_m", {31'h0, csr_rvalid}, 32'h0);

    // NA4 handling on entry 4
`ifdef PMP_NA4_EN
    exp_cfg4 = 32'h0000_0011;
`else
    exp_cfg4 = 32'h0000_0001;
`endif
    csr_op(1'b1, 1'b0, 12'h3A1, 32'h0000_0011, 2'b11);
    check("na4_cfg4", cfg_o[1], exp_cfg4);

    // Simultaneous write+read returns the pre-write value
    csr_op(1'b1, 1'b0, 12'h3B3, 32'h0000_0011, 2'b11);
    csr_op(1'b1, 1'b1, 12'h3B3, 32'h0000_0022, 2'b11);
    check("wr_rd_old", csr_rdata, 32'h0000_0011);
    check("wr_rd_new_bus", addr_o[3], 32'h0000_0022);

    // Reset hitting an in-flight read
    @(negedge clk);
    csr_re = 1'b1; csr_addr = 12'h3B3; priv_mode = 2'b11;
    #2 rst_n = 1'b0;
    @(negedge clk);
    csr_re = 1'b0;
    check("rst_drop_rvalid", {31'h0, csr_rvalid}, 32'h0);
    check("rst_hold_rdata", csr_rdata, 32'h0);
    check("rst_hold_cfg0", cfg_o[0], 32'h0);
    check("rst_hold_addr3", addr_o[3], 32'h0);
    @(negedge clk);
    check("rst_hold_rvalid2", {31'h0, csr_rvalid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rvalid", {31'h0, csr_rvalid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pmp_csr_file.md
Name: pmp_csr_file

Overview:
- Machine-mode CSR storage for the 16-entry PMP unit: holds pmpcfg0–3 and pmpaddr0–15.
- Services CSR reads and writes from the CSR/decode stage.
- Enforces lock and WARL rules on writes.
- Drives the pmpcfgN_data / pmpaddrN_data buses consumed directly by the downstream PMP permission checker.
- Sits between the CSR access path and the PMP checker; every output bus is a flop output.

Parameters:
- PMP_ENTRIES, 16, number of implemented entries (4, 8, 12 or 16). Unimplemented entries read 0, their writes are dropped, and their output bytes/words are tied 0.
- PMPCFG_BASE, 12'h3A0, CSR address of pmpcfg0 (pmpcfg1..3 follow consecutively).
- PMPADDR_BASE, 12'h3B0, CSR address of pmpaddr0 (pmpaddr1..15 follow consecutively).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- csr_addr  input  12  CSR address of current access
- csr_we  input  1  write strobe, single-cycle
- csr_re  input  1  read strobe, single-cycle
- csr_wdata  input  32  final write value (RMW already resolved upstream)
- priv_mode  input  2  current privilege (2'b11 = M)
- csr_rdata  output  32  read data, registered
- csr_rvalid  output  1  one-cycle pulse qualifying csr_rdata
- csr_illegal  output  1  one-cycle pulse: access to a PMP address while priv_mode != M
- pmp_update  output  1  one-cycle pulse after any write that changed stored state
- pmpcfg0_data..pmpcfg3_data  output  32 each  packed cfg bytes {cfg3,cfg2,cfg1,cfg0} per register; bit layout per byte {L,2'b00,A[1:0],X,W,R}
- pmpaddr0_data..pmpaddr15_data  output  32 each  stored pmpaddr values

Behaviour:
- Reset (async assert, sync release): all cfg/addr registers 0; csr_rdata = 0; csr_rvalid, csr_illegal and pmp_update = 0. An in-flight read is dropped and rvalid is never raised for it.
- Address hit: csr_addr is in [PMPCFG_BASE, PMPCFG_BASE+3] or [PMPADDR_BASE, PMPADDR_BASE+15]. Non-hit accesses are ignored completely: no rvalid, no illegal.
- Privilege: a hit with csr_we or csr_re while priv_mode != 2'b11:
  - pulses csr_illegal on the next cycle;
  - no state change, no rvalid.
- Read: a hit with csr_re at edge N presents csr_rdata with csr_rvalid = 1 during cycle N+1. csr_rdata holds its value until the next read.
- Simultaneous csr_we and csr_re to the same address: rdata returns the pre-write value.
- Write timing: a hit with csr_we at edge N updates storage at edge N. The output buses reflect the new value in cycle N+1, and pmp_update pulses in cycle N+1 only if at least one stored bit changed.
- pmpcfg write, byte-granular, evaluated per entry i:
  - If stored cfg_i.L = 1, byte i is unchanged.
  - Otherwise store the byte with bits [6:5] forced to 0.
  - If the new R=0 and W=1, store W=0.
  - A is handled per the Optional Feature.
- pmpaddr_i write is ignored if:
  - cfg_i.L = 1; or
  - i < 15, cfg_(i+1).L = 1 and cfg_(i+1).A = 2'b01 (TOR) — lock-protected top-of-range base.
- Lock decisions use stored (pre-write) cfg values. A single pmpcfg write setting L does not block another field written in the same cycle.
- L is sticky: cleared only by rst_n.
- Back-to-back accesses every cycle are supported with no stalls. There is no busy state.

Optional Feature:
- Macro: PMP_NA4_EN.
- Defined: A = 2'b10 (NA4) is stored as written.
- Undefined: a write carrying A = 2'b10 keeps the previously stored A field for that entry. All other fields of the byte are written normally.

Test Plan:
- Reset then read 0x3A0 with priv_mode = 2'b11 → next cycle csr_rvalid = 1, csr_rdata = 32'h0; pmp_update stays 0.
- Write 0x3B2 = 32'h2000_0400, then read 0x3B2 → rdata = 32'h2000_0400; pmpaddr2_data = 32'h2000_0400 in the cycle after the write; pmp_update pulses once. Repeating the identical write gives no pmp_update.
- Write 0x3A0 = 32'h0000_8F02 → cfg0 stored 8'h00 (R=0, W=1 cleared); cfg1 stored 8'h8F (bits [6:5] of 0x8F are already 0).
- With cfg1 = 8'h89 (L=1, A=TOR, R=1): write 0x3B0 = 32'h1234 and 0x3B1 = 32'h5678 → both ignored, pmpaddr0/1_data unchanged. A following write 0x3A0 = 32'h0 leaves cfg1 = 8'h89 and no pmp_update.
- priv_mode = 2'b00: write 0x3B5 = 32'hFFFF_FFFF → csr_illegal pulses one cycle, pmpaddr5_data unchanged, no rvalid.
- Write 0x3A1 = 32'h0000_0011 → with PMP_NA4_EN, cfg4 = 8'h11; without it, cfg4 = 8'h01. Separately, assert rst_n low in the cycle after a read strobe → csr_rvalid stays 0, and all outputs are 0 while reset is held.
